parking_gate_arbiter: RTL and testbench

//   Single-lane parking gate controller. Arbitrates entry/exit requests for one shared barrier,

---
 rtl/parking_gate_arbiter.sv | 128 ++++++++++++
 tb/tb_parking_gate_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Single-lane parking gate: arbitrates entry/exit requests for one shared barrier,
// follows each vehicle through the a/b sensor sequence and keeps the occupancy count.
module parking_gate_arbiter #(
    parameter int CAPACITY     = 7,
    parameter int CNT_W        = 3,
    parameter int OPEN_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             req_in,
    input  logic             req_out,
    output logic             gnt_in,
    output logic             gnt_out,
    output logic             barrier,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout
);

    localparam int               TMR_W   = (OPEN_TIMEOUT > 2) ? $clog2(OPEN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic             DIR_IN  = 1'b0;
    localparam logic             DIR_OUT = 1'b1;

    typedef enum logic [3:0] {
        IDLE, IN_WAIT, IN_A, IN_AB, IN_B, OUT_WAIT, OUT_B, OUT_AB, OUT_A
    } state_t;

    state_t           state, track_nxt;
    logic [TMR_W-1:0] timer;
    logic             last_dir;
    logic [1:0]       ab;
    logic             ok_in, ok_out, pick_in, pick_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CAP) ? CAP : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign full  = (count == CAP);
    assign empty = (count == '0);
    assign ab    = {a, b};

    // Round-robin: on contention the direction not served last wins
    assign ok_in    = req_in & ~full;
    assign ok_out   = req_out & ~empty;
    assign pick_in  = ok_in & (~ok_out | (last_dir == DIR_OUT));
    assign pick_out = ok_out & ~pick_in;

    // Sensor tracking: forward progress, one-step reversal, otherwise hold
    always_comb begin
        track_nxt = state;
        case (state)
            IN_WAIT:  if (ab == 2'b10) track_nxt = IN_A;
            IN_A:     if (ab == 2'b11) track_nxt = IN_AB;
                      else if (ab == 2'b00) track_nxt = IN_WAIT;
            IN_AB:    if (ab == 2'b01) track_nxt = IN_B;
                      else if (ab == 2'b10) track_nxt = IN_A;
            IN_B:     if (ab == 2'b00) track_nxt = IDLE;
                      else if (ab == 2'b11) track_nxt = IN_AB;
            OUT_WAIT: if (ab == 2'b01) track_nxt = OUT_B;
            OUT_B:    if (ab == 2'b11) track_nxt = OUT_AB;
                      else if (ab == 2'b00) track_nxt = OUT_WAIT;
            OUT_AB:   if (ab == 2'b10) track_nxt = OUT_A;
                      else if (ab == 2'b01) track_nxt = OUT_B;
            OUT_A:    if (ab == 2'b00) track_nxt = IDLE;
                      else if (ab == 2'b11) track_nxt = OUT_AB;
            default:  track_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            barrier  <= 1'b0;
            gnt_in   <= 1'b0;
            gnt_out  <= 1'b0;
            timeout  <= 1'b0;
            timer    <= '0;
            last_dir <= DIR_IN;
        end else begin
            gnt_in  <= 1'b0;
            gnt_out <= 1'b0;
            timeout <= 1'b0;
            if (state == IDLE) begin
                timer <= '0;
                if (pick_in) begin
                    state    <= IN_WAIT;
                    gnt_in   <= 1'b1;
                    barrier  <= 1'b1;
                    last_dir <= DIR_IN;
                end else if (pick_out) begin
                    state    <= OUT_WAIT;
                    gnt_out  <= 1'b1;
                    barrier  <= 1'b1;
                    last_dir <= DIR_OUT;
                end else begin
                    barrier  <= 1'b0;
                end
            end else if (track_nxt != state) begin
                // Any sensor progress, including completion, takes priority over the timer
                state   <= track_nxt;
                timer   <= '0;
                barrier <= (track_nxt != IDLE);
                if (state == IN_B && track_nxt == IDLE)
                    count <= sat_inc(count);
                else if (state == OUT_A && track_nxt == IDLE)
                    count <= sat_dec(count);
            end else if (timer == TMR_MAX) begin
                state   <= IDLE;
                timer   <= '0;
                barrier <= 1'b0;
                timeout <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: stimulus pushes expected output events,
// a negedge monitor pops and compares each time the DUT shows a pulse or an edge.
module tb_parking_gate_arbiter;

    localparam int CAP = 7;

    typedef struct packed {
        logic       gi;
        logic       go;
        logic       to;
        logic       bar;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0, b = 1'b0;
    logic       req_in = 1'b0, req_out = 1'b0;
    logic       gnt_in, gnt_out, barrier, full, empty, timeout;
    logic [2:0] count;

    int  checks = 0;
    int  errors = 0;
    int  cnt_m  = 0;
    ev_t q[$];

    parking_gate_arbiter #(.CAPACITY(7), .CNT_W(3), .OPEN_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .req_in(req_in), .req_out(req_out),
        .gnt_in(gnt_in), .gnt_out(gnt_out), .barrier(barrier), .count(count),
        .full(full), .empty(empty), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] v);
        {a, b} = v;
        tick();
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic push_ev(input logic gi, input logic go, input logic to, input logic bar);
        ev_t e;
        e.gi    = gi;
        e.go    = go;
        e.to    = to;
        e.bar   = bar;
        e.cnt   = 3'(cnt_m);
        e.full  = (cnt_m == CAP);
        e.empty = (cnt_m == 0);
        q.push_back(e);
    endtask

    task automatic grant_in();
        req_in = 1'b1;
        push_ev(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        req_in = 1'b0;
    endtask

    task automatic grant_out();
        req_out = 1'b1;
        push_ev(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        req_out = 1'b0;
    endtask

    task automatic walk_in();
        set_ab(2'b10);
        set_ab(2'b11);
        set_ab(2'b01);
        chk("in_barrier_mid", barrier, 1);
        cnt_m++;
        push_ev(1'b0, 1'b0, 1'b0, 1'b0);
        set_ab(2'b00);
        chk("in_count_done", count, cnt_m);
    endtask

    task automatic walk_out();
        set_ab(2'b01);
        set_ab(2'b11);
        set_ab(2'b10);
        chk("out_barrier_mid", barrier, 1);
        cnt_m--;
        push_ev(1'b0, 1'b0, 1'b0, 1'b0);
        set_ab(2'b00);
        chk("out_count_done", count, cnt_m);
    endtask

    // Monitor: every pulse or barrier/count change must match the next expected event
    initial begin
        logic [2:0] prev_cnt;
        logic       prev_bar;
        ev_t        got, e;
        prev_cnt = '0;
        prev_bar = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_cnt = count;
                prev_bar = barrier;
            end else if (gnt_in || gnt_out || timeout || count != prev_cnt || barrier != prev_bar) begin
                got = '{gnt_in, gnt_out, timeout, barrier, count, full, empty};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %b with nothing expected", got);
                end else begin
                    e = q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL event {gi,go,to,bar,cnt,full,empty}: got %b expected %b", got, e);
                    end
                end
                prev_cnt = count;
                prev_bar = barrier;
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_barrier", barrier, 0);
        chk("rst_count", count, 0);
        chk("rst_gnt", {gnt_in, gnt_out}, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        reset = 1'b0;
        tick();

        // Exit request on an empty lot is ignored
        req_out = 1'b1;
        repeat (5) tick();
        chk("t1_barrier", barrier, 0);
        chk("t1_count", count, 0);
        req_out = 1'b0;
        tick();

        // Simple entry
        grant_in();
        chk("t2_gnt_in", gnt_in, 1);
        chk("t2_barrier", barrier, 1);
        walk_in();
        chk("t2_barrier_closed", barrier, 0);

        // Contention after an entry: exit wins, then the held entry request
        grant_in(); walk_in();
        grant_in(); walk_in();
        req_in  = 1'b1;
        req_out = 1'b1;
        push_ev(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        req_out = 1'b0;
        chk("t3_gnt_in_blocked", gnt_in, 0);
        set_ab(2'b01);
        set_ab(2'b11);
        set_ab(2'b10);
        cnt_m--;
        push_ev(1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(1'b1, 1'b0, 1'b0, 1'b1);
        set_ab(2'b00);
        chk("t3_count_after_exit", count, 2);
        chk("t3_idle_gap", barrier, 0);
        tick();
        req_in = 1'b0;
        chk("t3_gnt_in_after", gnt_in, 1);
        walk_in();

        // Fill, full refuses entry, then entry with reversals
        repeat (4) begin
            grant_in();
            walk_in();
        end
        chk("t4_full", full, 1);
        req_in = 1'b1;
        repeat (4) tick();
        chk("t4_refused_barrier", barrier, 0);
        req_in = 1'b0;
        grant_out(); walk_out();
        grant_in();
        set_ab(2'b10);
        set_ab(2'b11);
        set_ab(2'b10);
        set_ab(2'b11);
        set_ab(2'b01);
        chk("t4_rev_count_mid", count, 6);
        cnt_m++;
        push_ev(1'b0, 1'b0, 1'b0, 1'b0);
        set_ab(2'b00);
        chk("t4_rev_count", count, 7);

        // Timeout from IN_WAIT
        grant_out(); walk_out();
        grant_in();
        repeat (15) tick();
        chk("t5a_barrier_before", barrier, 1);
        push_ev(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t5a_timeout", timeout, 1);
        chk("t5a_barrier", barrier, 0);
        chk("t5a_count", count, 6);

        // Timeout from IN_AB
        grant_in();
        set_ab(2'b10);
        set_ab(2'b11);
        repeat (15) tick();
        chk("t5b_barrier_before", barrier, 1);
        push_ev(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t5b_timeout", timeout, 1);
        chk("t5b_count", count, 6);
        set_ab(2'b00);

        // Completion on the cycle the timer expires wins over timeout
        grant_in();
        set_ab(2'b10);
        set_ab(2'b11);
        set_ab(2'b01);
        repeat (15) tick();
        chk("t5c_barrier_before", barrier, 1);
        cnt_m++;
        push_ev(1'b0, 1'b0, 1'b0, 1'b0);
        set_ab(2'b00);
        chk("t5c_no_timeout", timeout, 0);
        chk("t5c_count", count, 7);

        // Reset in the middle of an entry
        grant_out(); walk_out();
        grant_out(); walk_out();
        grant_in();
        set_ab(2'b10);
        set_ab(2'b11);
        chk("t6_count_before", count, 5);
        #2 reset = 1'b1;
        #1;
        chk("t6_barrier", barrier, 0);
        chk("t6_count", count, 0);
        chk("t6_pulses", {gnt_in, gnt_out, timeout}, 0);
        cnt_m = 0;
        {a, b} = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("t6_idle_after", barrier, 0);
        grant_in();
        walk_in();

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
